stripe_dispatch: RTL and testbench
==================================

Name: stripe_dispatch

Overview:
- Schedules stripe jobs onto a bank of n_stripes stripe blocks.
- A job is a tag pair, stride pair, iteration limit and PE instruction.
- Accepts jobs through a valid/ready command port and buffers them in a FIFO.
- Issues each job to a free stripe with a one-cycle tag_write pulse on a shared configuration bus, then tracks each stripe busy until that stripe reports done.

Parameters:
tag_width, 12, width of tags, strides, iteration limit
instr_width, 7, PE instruction width
n_stripes, 4, number of stripes served (2..8)
fifo_depth, 4, command FIFO entries (power of 2, >=2)
cnt_width, 16, completed-job counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  sync: empty the FIFO; busy flags unaffected
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= not full)
cmd_tagA  in  tag_width  operand A start tag
cmd_tagB  in  tag_width  operand B start tag
cmd_strideA  in  tag_width  A tag stride
cmd_strideB  in  tag_width  B tag stride
cmd_iter_lim  in  tag_width  iteration limit
cmd_instr  in  instr_width  PE instruction
stripe_done  in  n_stripes  1-cycle pulse per stripe at full iteration
tag_write  out  n_stripes  one-hot config write strobe
tagA_OUT  out  tag_width  shared bus, valid while tag_write != 0
tagB_OUT  out  tag_width  shared bus
strideA_OUT  out  tag_width  shared bus
strideB_OUT  out  tag_width  shared bus
iter_lim_OUT  out  tag_width  shared bus
instr_OUT  out  instr_width  shared bus
busy  out  n_stripes  stripe holds an unfinished job
idle  out  1  FIFO empty and busy == 0
done_count  out  cnt_width  completed jobs, wraps
err  out  1  sticky: done pulse from a non-busy stripe

Behaviour:
- Reset (async) clears:
  - FIFO pointers and count: empty, cmd_ready=1.
  - tag_write, all bus outputs, busy, done_count, err: all 0.
  - rr pointer = n_stripes-1, so stripe 0 is served first.
  - idle=1.
- Reset asserted mid-operation drops everything; an in-flight tag_write pulse ends immediately.
- FIFO:
  - Push on edge when cmd_valid & cmd_ready.
  - cmd_ready is combinational from the registered count.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - Full with pop in the same cycle: cmd_ready stays 0 that cycle; no push.
  - Pointers wrap modulo fifo_depth.
- Dispatch, evaluated at each edge from registered state:
  - Free stripes: free = ~busy.
  - If the FIFO is non-empty, free != 0 and flush=0, pick the first free stripe in round-robin order, starting at rr+1 and wrapping at n_stripes.
  - On that pick: tag_write <= onehot(sel); bus regs <= FIFO head; pop; busy[sel] <= 1; rr <= sel.
  - Otherwise tag_write <= 0; bus regs hold their last value.
  - tag_write is high exactly one cycle per job. At most one dispatch per cycle.
  - Back-to-back dispatches on consecutive cycles are allowed to different stripes.
- Latency: a job pushed at edge k, with a free stripe, shows tag_write during the cycle after edge k+1.
- Completion:
  - stripe_done[i] with busy[i]=1 clears busy[i] at that edge and increments done_count (mod 2^cnt_width).
  - Multiple done bits in one cycle add their popcount.
  - A stripe freed at edge k is eligible for dispatch at edge k+1, not at edge k.
  - stripe_done[i] with busy[i]=0 is ignored for busy and count, and sets err (cleared only by rst).
- Flush:
  - Empties the FIFO at that edge and blocks that edge's dispatch and push.
  - Busy stripes keep running and report done normally.
- idle is combinational from registered state.

Test Plan:
1. Reset, then push 1 job (tagA=0x010, tagB=0x020, strideA=1, strideB=2, lim=8, instr=0x21) -> tag_write=0001 for exactly one cycle, with the bus showing those values, 1 cycle after acceptance; busy=0001, idle=0.
2. Push 5 jobs back-to-back, no done -> tag_write 0001, 0010, 0100, 1000 on consecutive cycles; 5th job stays queued; busy=1111; cmd_ready stays 1.
3. With busy=1111 and 4 queued, push a 5th -> cmd_ready=0 and the 5th push is refused. Then pulse stripe_done=0100 -> busy[2] clears; next edge dispatches to stripe 2; done_count=1.
4. stripe_done=0011 in one cycle with busy=0011 -> done_count +2, busy=0000; rr resumes after the last granted stripe.
5. stripe_done=1000 while busy=0000 -> err=1, done_count unchanged, busy unchanged.
6. Queue 3 jobs while all stripes are busy, assert flush -> FIFO empty, no tag_write, busy unchanged. Done pulses drain busy; idle=1 once busy=0. Async rst mid tag_write pulse -> all outputs 0 immediately.

Source files
------------

// File: rtl/stripe_dispatch_if.sv
// Command port and shared stripe configuration bus of the stripe dispatcher.
// The dispatcher uses the slave side; the job source and stripe bank use master.
interface stripe_dispatch_if #(
    parameter int tag_width   = 12,
    parameter int instr_width = 7,
    parameter int n_stripes   = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [tag_width-1:0]   cmd_tagA;
    logic [tag_width-1:0]   cmd_tagB;
    logic [tag_width-1:0]   cmd_strideA;
    logic [tag_width-1:0]   cmd_strideB;
    logic [tag_width-1:0]   cmd_iter_lim;
    logic [instr_width-1:0] cmd_instr;
    logic [n_stripes-1:0]   stripe_done;
    logic [n_stripes-1:0]   tag_write;
    logic [tag_width-1:0]   tagA_OUT;
    logic [tag_width-1:0]   tagB_OUT;
    logic [tag_width-1:0]   strideA_OUT;
    logic [tag_width-1:0]   strideB_OUT;
    logic [tag_width-1:0]   iter_lim_OUT;
    logic [instr_width-1:0] instr_OUT;

    modport master (
        output cmd_valid, cmd_tagA, cmd_tagB, cmd_strideA, cmd_strideB, cmd_iter_lim, cmd_instr,
        output stripe_done,
        input  cmd_ready, tag_write, tagA_OUT, tagB_OUT, strideA_OUT, strideB_OUT,
        input  iter_lim_OUT, instr_OUT
    );

    modport slave (
        input  cmd_valid, cmd_tagA, cmd_tagB, cmd_strideA, cmd_strideB, cmd_iter_lim, cmd_instr,
        input  stripe_done,
        output cmd_ready, tag_write, tagA_OUT, tagB_OUT, strideA_OUT, strideB_OUT,
        output iter_lim_OUT, instr_OUT
    );
endinterface

// File: rtl/stripe_dispatch.sv
// Buffers stripe jobs in a FIFO and issues each to a free stripe in round-robin
// order with a one-cycle config strobe, tracking stripes busy until they report done.
module stripe_dispatch #(
    parameter int tag_width   = 12,
    parameter int instr_width = 7,
    parameter int n_stripes   = 4,
    parameter int fifo_depth  = 4,
    parameter int cnt_width   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    stripe_dispatch_if.slave     bus,
    output logic [n_stripes-1:0] busy,
    output logic                 idle,
    output logic [cnt_width-1:0] done_count,
    output logic                 err
);
    localparam int ptr_w = $clog2(fifo_depth);
    localparam int sel_w = $clog2(n_stripes);
    localparam logic [ptr_w-1:0]     ptr_one     = ptr_w'(1);
    localparam logic [ptr_w:0]       cnt_one     = (ptr_w + 1)'(1);
    localparam logic [ptr_w:0]       cnt_full    = (ptr_w + 1)'(fifo_depth);
    localparam logic [ptr_w:0]       cnt_empty   = (ptr_w + 1)'(0);
    localparam logic [sel_w-1:0]     rr_init     = sel_w'(n_stripes - 1);
    localparam logic [n_stripes-1:0] stripe_one  = n_stripes'(1);
    localparam logic [n_stripes-1:0] stripe_none = n_stripes'(0);

    typedef struct packed {
        logic [tag_width-1:0]   tag_a;
        logic [tag_width-1:0]   tag_b;
        logic [tag_width-1:0]   stride_a;
        logic [tag_width-1:0]   stride_b;
        logic [tag_width-1:0]   iter_lim;
        logic [instr_width-1:0] instr;
    } job_t;

    function automatic logic [cnt_width-1:0] popcount(input logic [n_stripes-1:0] v);
        logic [cnt_width-1:0] sum;
        sum = cnt_width'(0);
        for (int i = 0; i < n_stripes; i++) begin
            sum = sum + cnt_width'(v[i]);
        end
        return sum;
    endfunction

    job_t                 fifo_mem_r [fifo_depth];
    logic [ptr_w-1:0]     wr_ptr_r, rd_ptr_r;
    logic [ptr_w:0]       count_r;
    logic [sel_w-1:0]     rr_r;
    logic [n_stripes-1:0] busy_r, tag_write_r;
    logic [cnt_width-1:0] done_count_r;
    logic                 err_r;
    job_t                 bus_r;

    job_t                 cmd_job_s, head_s;
    logic                 push_s, dispatch_s, sel_found_s;
    logic [sel_w-1:0]     sel_s, cand_s;
    logic [n_stripes-1:0] free_s, grant_s, done_hit_s, done_stray_s;

    assign cmd_job_s    = '{bus.cmd_tagA, bus.cmd_tagB, bus.cmd_strideA, bus.cmd_strideB,
                            bus.cmd_iter_lim, bus.cmd_instr};
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign free_s       = ~busy_r;
    assign done_hit_s   = bus.stripe_done & busy_r;
    assign done_stray_s = bus.stripe_done & ~busy_r;
    assign push_s       = bus.cmd_valid & bus.cmd_ready & ~flush;
    assign dispatch_s   = (count_r != cnt_empty) & sel_found_s & ~flush;
    assign grant_s      = dispatch_s ? (stripe_one << sel_s) : stripe_none;

    // Round-robin search for the first free stripe after the last one granted.
    always_comb begin
        sel_found_s = 1'b0;
        sel_s       = rr_r;
        cand_s      = rr_r;
        for (int k = 1; k <= n_stripes; k++) begin
            cand_s = sel_w'((int'(rr_r) + k) % n_stripes);
            if (!sel_found_s && free_s[cand_s]) begin
                sel_found_s = 1'b1;
                sel_s       = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Job storage; contents need no reset since the pointers qualify them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= cmd_job_s;
        end
    end

    // FIFO pointers and occupancy; flush discards everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {ptr_w{1'b0}};
            rd_ptr_r <= {ptr_w{1'b0}};
            count_r  <= cnt_empty;
        end else if (flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= cnt_empty;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + ptr_one;
            if (dispatch_s) rd_ptr_r <= rd_ptr_r + ptr_one;
            case ({push_s, dispatch_s})
                2'b10:   count_r <= count_r + cnt_one;
                2'b01:   count_r <= count_r - cnt_one;
                default: count_r <= count_r;
            endcase
        end
    end

    // Dispatch strobe, shared bus, busy tracking, completion count and stray-done error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_write_r  <= stripe_none;
            bus_r        <= '0;
            busy_r       <= stripe_none;
            rr_r         <= rr_init;
            done_count_r <= cnt_width'(0);
            err_r        <= 1'b0;
        end else begin
            tag_write_r  <= grant_s;
            busy_r       <= (busy_r & ~done_hit_s) | grant_s;
            done_count_r <= done_count_r + popcount(done_hit_s);
            err_r        <= err_r | (|done_stray_s);
            if (dispatch_s) begin
                bus_r <= head_s;
                rr_r  <= sel_s;
            end
        end
    end

    assign bus.cmd_ready    = (count_r != cnt_full);
    assign bus.tag_write    = tag_write_r;
    assign bus.tagA_OUT     = bus_r.tag_a;
    assign bus.tagB_OUT     = bus_r.tag_b;
    assign bus.strideA_OUT  = bus_r.stride_a;
    assign bus.strideB_OUT  = bus_r.stride_b;
    assign bus.iter_lim_OUT = bus_r.iter_lim;
    assign bus.instr_OUT    = bus_r.instr;
    assign busy             = busy_r;
    assign idle             = (count_r == cnt_empty) && (busy_r == stripe_none);
    assign done_count       = done_count_r;
    assign err              = err_r;
endmodule

// File: tb/tb_stripe_dispatch.sv
// Scenario bench for stripe_dispatch: accepted jobs are queued as expectations
// and matched in order against the shared bus whenever tag_write fires.
module tb_stripe_dispatch;
    localparam int tw = 12;
    localparam int iw = 7;
    localparam int ns = 4;

    typedef struct packed {
        logic [tw-1:0] ta;
        logic [tw-1:0] tbv;
        logic [tw-1:0] sa;
        logic [tw-1:0] sb;
        logic [tw-1:0] lim;
        logic [iw-1:0] ins;
    } job_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic [ns-1:0] busy;
    logic          idle;
    logic [15:0]   done_count;
    logic          err;
    int            total_cnt = 0;
    int            bad_cnt = 0;
    job_t          exp_q[$];

    stripe_dispatch_if #(.tag_width(tw), .instr_width(iw), .n_stripes(ns)) dif();

    stripe_dispatch #(.tag_width(tw), .instr_width(iw), .n_stripes(ns),
                      .fifo_depth(4), .cnt_width(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(dif),
        .busy(busy), .idle(idle), .done_count(done_count), .err(err)
    );

    always #5 clk = ~clk;

    function automatic job_t mk_job(input int i);
        job_t j;
        j.ta  = 12'h100 + 12'(i);
        j.tbv = 12'h200 + 12'(3 * i);
        j.sa  = 12'(i + 1);
        j.sb  = 12'(2 * i + 1);
        j.lim = 12'h040 + 12'(i);
        j.ins = 7'(i + 5);
        return j;
    endfunction

    // Mid-cycle scoreboard pop on every strobe, then advance to just after the next edge.
    task automatic tick();
        job_t j, got;
        @(negedge clk);
        if (!rst && dif.tag_write != 4'b0000) begin
            got = '{dif.tagA_OUT, dif.tagB_OUT, dif.strideA_OUT, dif.strideB_OUT,
                    dif.iter_lim_OUT, dif.instr_OUT};
            total_cnt++;
            if (exp_q.size() == 0) begin
                bad_cnt++;
                $display("FAIL sb_extra: tag_write=%b but no accepted job pending", dif.tag_write);
            end else begin
                j = exp_q.pop_front();
                if (got !== j) begin
                    bad_cnt++;
                    $display("FAIL sb_bus: got %h want %h", got, j);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input job_t j);
        dif.cmd_valid    = 1'b1;
        dif.cmd_tagA     = j.ta;
        dif.cmd_tagB     = j.tbv;
        dif.cmd_strideA  = j.sa;
        dif.cmd_strideB  = j.sb;
        dif.cmd_iter_lim = j.lim;
        dif.cmd_instr    = j.ins;
        if (dif.cmd_ready === 1'b1 && !flush) exp_q.push_back(j);
        tick();
        dif.cmd_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [ns-1:0] d);
        dif.stripe_done = d;
        tick();
        dif.stripe_done = 4'b0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dif.cmd_valid = 1'b0;
        dif.stripe_done = 4'b0000;
        flush = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        dif.cmd_tagA = 12'h000; dif.cmd_tagB = 12'h000; dif.cmd_strideA = 12'h000;
        dif.cmd_strideB = 12'h000; dif.cmd_iter_lim = 12'h000; dif.cmd_instr = 7'h00;
        do_reset();
        total_cnt++; if (dif.tag_write !== 4'b0000) begin bad_cnt++; $display("FAIL rst_tw: got %b want 0000", dif.tag_write); end
        total_cnt++; if (busy !== 4'b0000) begin bad_cnt++; $display("FAIL rst_busy: got %b want 0000", busy); end
        total_cnt++; if (idle !== 1'b1) begin bad_cnt++; $display("FAIL rst_idle: got %b want 1", idle); end
        total_cnt++; if (dif.cmd_ready !== 1'b1) begin bad_cnt++; $display("FAIL rst_ready: got %b want 1", dif.cmd_ready); end
        total_cnt++; if (done_count !== 16'h0000 || err !== 1'b0) begin bad_cnt++; $display("FAIL rst_cnt_err: got %h/%b want 0000/0", done_count, err); end
        total_cnt++; if (dif.tagA_OUT !== 12'h000 || dif.instr_OUT !== 7'h00) begin bad_cnt++; $display("FAIL rst_bus: got %h/%h want 000/00", dif.tagA_OUT, dif.instr_OUT); end
    endtask

    task automatic test_single();
        job_t j1;
        j1 = '{12'h010, 12'h020, 12'h001, 12'h002, 12'h008, 7'h21};
        offer(j1);
        total_cnt++; if (dif.tag_write !== 4'b0000 || idle !== 1'b0) begin bad_cnt++; $display("FAIL t1_accept: tw=%b idle=%b want 0000/0", dif.tag_write, idle); end
        tick();
        total_cnt++; if (dif.tag_write !== 4'b0001) begin bad_cnt++; $display("FAIL t1_tw: got %b want 0001", dif.tag_write); end
        total_cnt++; if (busy !== 4'b0001) begin bad_cnt++; $display("FAIL t1_busy: got %b want 0001", busy); end
        total_cnt++; if ({dif.tagA_OUT, dif.tagB_OUT, dif.strideA_OUT, dif.strideB_OUT, dif.iter_lim_OUT, dif.instr_OUT} !== {12'h010, 12'h020, 12'h001, 12'h002, 12'h008, 7'h21}) begin
            bad_cnt++; $display("FAIL t1_bus: got %h %h %h %h %h %h", dif.tagA_OUT, dif.tagB_OUT, dif.strideA_OUT, dif.strideB_OUT, dif.iter_lim_OUT, dif.instr_OUT); end
        tick();
        total_cnt++; if (dif.tag_write !== 4'b0000) begin bad_cnt++; $display("FAIL t1_pulse_len: got %b want 0000", dif.tag_write); end
        pulse_done(4'b0001);
        total_cnt++; if (busy !== 4'b0000 || done_count !== 16'd1 || idle !== 1'b1) begin bad_cnt++; $display("FAIL t1_done: busy=%b cnt=%0d idle=%b want 0000/1/1", busy, done_count, idle); end
    endtask

    task automatic test_back_to_back();
        logic [ns-1:0] exp_tw;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            offer(mk_job(i));
            exp_tw = (i == 0) ? 4'b0000 : (4'b0001 << (i - 1));
            total_cnt++; if (dif.tag_write !== exp_tw) begin bad_cnt++; $display("FAIL b2b_tw%0d: got %b want %b", i, dif.tag_write, exp_tw); end
            total_cnt++; if (dif.cmd_ready !== 1'b1) begin bad_cnt++; $display("FAIL b2b_ready%0d: got %b want 1", i, dif.cmd_ready); end
        end
        tick();
        total_cnt++; if (dif.tag_write !== 4'b0000 || busy !== 4'b1111) begin bad_cnt++; $display("FAIL b2b_end: tw=%b busy=%b want 0000/1111", dif.tag_write, busy); end
    endtask

    task automatic test_full_and_done();
        offer(mk_job(10));
        offer(mk_job(11));
        offer(mk_job(12));
        total_cnt++; if (dif.cmd_ready !== 1'b0) begin bad_cnt++; $display("FAIL full_ready: got %b want 0", dif.cmd_ready); end
        offer(mk_job(13));
        total_cnt++; if (dif.cmd_ready !== 1'b0) begin bad_cnt++; $display("FAIL full_refuse: got %b want 0", dif.cmd_ready); end
        pulse_done(4'b0100);
        total_cnt++; if (busy !== 4'b1011 || done_count !== 16'd1 || dif.tag_write !== 4'b0000) begin bad_cnt++; $display("FAIL full_done: busy=%b cnt=%0d tw=%b want 1011/1/0000", busy, done_count, dif.tag_write); end
        tick();
        total_cnt++; if (dif.tag_write !== 4'b0100 || busy !== 4'b1111) begin bad_cnt++; $display("FAIL full_redispatch: tw=%b busy=%b want 0100/1111", dif.tag_write, busy); end
        total_cnt++; if (dif.cmd_ready !== 1'b1) begin bad_cnt++; $display("FAIL full_ready_back: got %b want 1", dif.cmd_ready); end
    endtask

    task automatic test_multi_done();
        do_reset();
        offer(mk_job(40));
        offer(mk_job(41));
        tick();
        total_cnt++; if (dif.tag_write !== 4'b0010 || busy !== 4'b0011) begin bad_cnt++; $display("FAIL md_setup: tw=%b busy=%b want 0010/0011", dif.tag_write, busy); end
        pulse_done(4'b0011);
        total_cnt++; if (done_count !== 16'd2 || busy !== 4'b0000) begin bad_cnt++; $display("FAIL md_count: cnt=%0d busy=%b want 2/0000", done_count, busy); end
        offer(mk_job(42));
        tick();
        total_cnt++; if (dif.tag_write !== 4'b0100 || busy !== 4'b0100) begin bad_cnt++; $display("FAIL md_rr: tw=%b busy=%b want 0100/0100", dif.tag_write, busy); end
        pulse_done(4'b0100);
        total_cnt++; if (done_count !== 16'd3) begin bad_cnt++; $display("FAIL md_count3: got %0d want 3", done_count); end
    endtask

    task automatic test_stray_done();
        total_cnt++; if (err !== 1'b0) begin bad_cnt++; $display("FAIL err_pre: got %b want 0", err); end
        pulse_done(4'b1000);
        total_cnt++; if (err !== 1'b1 || done_count !== 16'd3 || busy !== 4'b0000) begin bad_cnt++; $display("FAIL err_set: err=%b cnt=%0d busy=%b want 1/3/0000", err, done_count, busy); end
        tick();
        total_cnt++; if (err !== 1'b1) begin bad_cnt++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_flush_and_async_reset();
        do_reset();
        for (int i = 0; i < 7; i++) offer(mk_job(20 + i));
        total_cnt++; if (busy !== 4'b1111) begin bad_cnt++; $display("FAIL fl_setup: busy=%b want 1111", busy); end
        flush = 1'b1;
        exp_q.delete();
        offer(mk_job(27));
        flush = 1'b0;
        total_cnt++; if (dif.cmd_ready !== 1'b1 || idle !== 1'b0 || busy !== 4'b1111 || dif.tag_write !== 4'b0000) begin
            bad_cnt++; $display("FAIL fl_state: ready=%b idle=%b busy=%b tw=%b want 1/0/1111/0000", dif.cmd_ready, idle, busy, dif.tag_write); end
        pulse_done(4'b0001);
        tick();
        total_cnt++; if (dif.tag_write !== 4'b0000 || busy !== 4'b1110) begin bad_cnt++; $display("FAIL fl_empty: tw=%b busy=%b want 0000/1110", dif.tag_write, busy); end
        pulse_done(4'b1110);
        total_cnt++; if (busy !== 4'b0000 || idle !== 1'b1 || done_count !== 16'd4) begin bad_cnt++; $display("FAIL fl_drain: busy=%b idle=%b cnt=%0d want 0000/1/4", busy, idle, done_count); end
        offer(mk_job(30));
        tick();
        total_cnt++; if (dif.tag_write !== 4'b0001) begin bad_cnt++; $display("FAIL ar_pre: tw=%b want 0001", dif.tag_write); end
        #1 rst = 1'b1;
        #1;
        total_cnt++; if (dif.tag_write !== 4'b0000 || busy !== 4'b0000 || idle !== 1'b1 || done_count !== 16'd0 || dif.tagA_OUT !== 12'h000) begin
            bad_cnt++; $display("FAIL ar_clear: tw=%b busy=%b idle=%b cnt=%0d tagA=%h want 0000/0000/1/0/000", dif.tag_write, busy, idle, done_count, dif.tagA_OUT); end
        exp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_and_done();
        test_multi_done();
        test_stray_done();
        test_flush_and_async_reset();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
